// File: rtl/guarded_ctr_pkg.sv
// Shared types and helpers for the guarded counter scrubber.
package guarded_ctr_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_FAULT   = 2'b10,
    ST_RECOVER = 2'b11
  } state_e;

  // Command bus opcodes
  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  // Bit positions within the injection select
  localparam int INJ_PRI = 0;
  localparam int INJ_SHD = 1;

  // Guard width large enough to hold a popcount of 0..width/2
  function automatic int guard_bits(input int width);
    return $clog2(width / 2) + 1;
  endfunction

endpackage

// File: rtl/guarded_counter_scrubber_popcount_split.sv
// Splits a value into popcounts of its even-indexed and odd-indexed bits.
module popcount_split #(
  parameter int WIDTH = 8,
  parameter int GB    = 3
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [GB-1:0]    o_even,
  output logic [GB-1:0]    o_odd
);

  logic [GB-1:0] w_even;
  logic [GB-1:0] w_odd;

  // Accumulate one bit from each half per bit pair
  always_comb begin
    w_even = '0;
    w_odd  = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      w_even = w_even + GB'(i_val[2*i]);
      w_odd  = w_odd  + GB'(i_val[2*i+1]);
    end
  end

  assign o_even = w_even;
  assign o_odd  = w_odd;

endmodule

// File: rtl/guarded_counter_scrubber.sv
// Guarded counter with primary/shadow copies, continuous guard checking and
// single-copy upset recovery. Guards are always derived from the value being
// written; the injection hook perturbs stored values only.
module guarded_counter_scrubber
  import guarded_ctr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GUARD_BITS = guard_bits(WIDTH),
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [WIDTH-1:0]      i_cmd_data,
  input  logic                  i_inj_valid,
  input  logic [1:0]            i_inj_sel,
  input  logic [WIDTH-1:0]      i_inj_mask,
  output logic [WIDTH-1:0]      o_count,
  output logic [GUARD_BITS-1:0] o_even_guard,
  output logic [GUARD_BITS-1:0] o_odd_guard,
  output logic                  o_running,
  output logic                  o_fault,
  output logic                  o_fatal,
  output logic                  o_err_pulse,
  output logic [ERR_CNT_W-1:0]  o_err_count
);

  localparam int GB = GUARD_BITS;

  state_e               r_state;
  logic [WIDTH-1:0]     r_p_val, r_s_val;
  logic [GB-1:0]        r_p_eg, r_p_og, r_s_eg, r_s_og;
  logic                 r_resume;
  logic                 r_fatal;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0]     w_nxt_p, w_nxt_s;
  logic [GB-1:0]        w_nxt_p_eg, w_nxt_p_og, w_nxt_s_eg, w_nxt_s_og;
  logic [GB-1:0]        w_chk_p_eg, w_chk_p_og, w_chk_s_eg, w_chk_s_og;
  logic                 w_bad_p, w_bad_s, w_diverge, w_active, w_mismatch;
  logic                 w_cmd_fire;
  logic [WIDTH-1:0]     w_mask_p, w_mask_s;

  // Guards for the values about to be written
  popcount_split #(.WIDTH(WIDTH), .GB(GB)) u_pc_nxt_p (
    .i_val(w_nxt_p), .o_even(w_nxt_p_eg), .o_odd(w_nxt_p_og));
  popcount_split #(.WIDTH(WIDTH), .GB(GB)) u_pc_nxt_s (
    .i_val(w_nxt_s), .o_even(w_nxt_s_eg), .o_odd(w_nxt_s_og));

  // Guards recomputed from the stored values, for checking
  popcount_split #(.WIDTH(WIDTH), .GB(GB)) u_pc_chk_p (
    .i_val(r_p_val), .o_even(w_chk_p_eg), .o_odd(w_chk_p_og));
  popcount_split #(.WIDTH(WIDTH), .GB(GB)) u_pc_chk_s (
    .i_val(r_s_val), .o_even(w_chk_s_eg), .o_odd(w_chk_s_og));

  assign w_bad_p    = (w_chk_p_eg != r_p_eg) || (w_chk_p_og != r_p_og);
  assign w_bad_s    = (w_chk_s_eg != r_s_eg) || (w_chk_s_og != r_s_og);
  assign w_diverge  = (r_p_val != r_s_val);
  assign w_active   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_mismatch = w_active && (w_bad_p || w_bad_s || w_diverge);
  assign w_cmd_fire = i_cmd_valid && o_cmd_ready;

  assign w_mask_p = (i_inj_valid && i_inj_sel[INJ_PRI]) ? i_inj_mask : '0;
  assign w_mask_s = (i_inj_valid && i_inj_sel[INJ_SHD]) ? i_inj_mask : '0;

  // Next copy values on a normal IDLE/RUN edge: increment in RUN, LOAD overrides
  always_comb begin
    w_nxt_p = r_p_val;
    w_nxt_s = r_s_val;
    if (r_state == ST_RUN) begin
      w_nxt_p = r_p_val + WIDTH'(1);
      w_nxt_s = r_s_val + WIDTH'(1);
    end
    if (w_cmd_fire && (cmd_op_e'(i_cmd_op) == OP_LOAD)) begin
      w_nxt_p = i_cmd_data;
      w_nxt_s = i_cmd_data;
    end
  end

  // Controller: command handling, fault entry, error accounting and recovery
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_p_val   <= '0;
      r_p_eg    <= '0;
      r_p_og    <= '0;
      r_s_val   <= '0;
      r_s_eg    <= '0;
      r_s_og    <= '0;
      r_resume  <= 1'b0;
      r_fatal   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_mismatch) begin
            // Upset seen: freeze copies, remember whether to resume counting
            r_state  <= ST_FAULT;
            r_resume <= (r_state == ST_RUN);
          end else if (w_cmd_fire && (cmd_op_e'(i_cmd_op) == OP_CLEAR)) begin
            r_state   <= ST_IDLE;
            r_p_val   <= '0;
            r_p_eg    <= '0;
            r_p_og    <= '0;
            r_s_val   <= '0;
            r_s_eg    <= '0;
            r_s_og    <= '0;
            r_fatal   <= 1'b0;
            r_err_cnt <= '0;
          end else begin
            r_p_val <= w_nxt_p ^ w_mask_p;
            r_p_eg  <= w_nxt_p_eg;
            r_p_og  <= w_nxt_p_og;
            r_s_val <= w_nxt_s ^ w_mask_s;
            r_s_eg  <= w_nxt_s_eg;
            r_s_og  <= w_nxt_s_og;
            if (w_cmd_fire) begin
              case (cmd_op_e'(i_cmd_op))
                OP_START: if (!r_fatal) r_state <= ST_RUN;
                OP_STOP:  r_state <= ST_IDLE;
                default:  ;
              endcase
            end
          end
        end
        ST_FAULT: begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
          r_state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          // Prefer the shadow if intact, else the primary, else give up
          if (!w_bad_s) begin
            r_p_val <= r_s_val;
            r_p_eg  <= r_s_eg;
            r_p_og  <= r_s_og;
            r_state <= (r_resume && !r_fatal) ? ST_RUN : ST_IDLE;
          end else if (!w_bad_p) begin
            r_s_val <= r_p_val;
            r_s_eg  <= r_p_eg;
            r_s_og  <= r_p_og;
            r_state <= (r_resume && !r_fatal) ? ST_RUN : ST_IDLE;
          end else begin
            r_p_val <= '0;
            r_p_eg  <= '0;
            r_p_og  <= '0;
            r_s_val <= '0;
            r_s_eg  <= '0;
            r_s_og  <= '0;
            r_fatal <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = w_active && !w_mismatch;
  assign o_count      = r_p_val;
  assign o_even_guard = r_p_eg;
  assign o_odd_guard  = r_p_og;
  assign o_running    = (r_state == ST_RUN);
  assign o_fault      = (r_state == ST_FAULT) || (r_state == ST_RECOVER);
  assign o_fatal      = r_fatal;
  assign o_err_pulse  = (r_state == ST_FAULT);
  assign o_err_count  = r_err_cnt;

endmodule
